load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DM_WORD_ADDR, default 1, dm_address format: 1 = doubleword index (addr>>3); 0 = byte address with addr[2:0] forced to 0.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  core requests an access this cycle.
REQ-005 req_ready  out  1  unit idle, request accepted when req_valid=1.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 addr  in  64  byte address of the access.
REQ-009 store_data  in  64  store operand; low bytes used for sub-doubleword stores.
REQ-010 load_data  out  64  extended load result.
REQ-011 done  out  1  one-cycle pulse: access complete.
REQ-012 fault  out  1  valid with done: misaligned or illegal access, no memory effect.
REQ-013 dm_address  out  64  address to data memory.
REQ-014 dm_write_data  out  64  doubleword written to data memory.
REQ-015 dm_mem_write  out  1  data memory write enable.
REQ-016 dm_mem_read  out  1  data memory read enable.
REQ-017 dm_read_data  in  64  data memory read data, valid the cycle after dm_mem_read is first asserted for an address.

Function
REQ-018 States SHALL be IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE.
REQ-019 Acceptance: req_valid=1 in IDLE at an edge latches req_write, funct3, addr, store_data; later input changes SHALL be ignored until back in IDLE.
REQ-020 Fault: addr not aligned to access size (H: addr[0]; W: addr[1:0]; D: addr[2:0]), funct3=111, or store with funct3[2]=1 SHALL go IDLE->RESP with fault=1, no dm_mem_read or dm_mem_write asserted.
REQ-021 Load: IDLE->RD->CAP->RESP->IDLE; dm_mem_read=1 in RD and CAP; dm_read_data captured at end of CAP; done=1 in RESP (third cycle after acceptance edge).
REQ-022 Load extraction: lane = addr[2:0], little-endian; B/H/W sign-extended from bit 7/15/31; BU/HU/WU zero-extended; D passed through.
REQ-023 load_data SHALL be updated only at end of CAP of a non-faulting load and hold otherwise.
REQ-024 SD store: IDLE->WR->RESP; dm_mem_write=1 for exactly one cycle (WR) with dm_write_data=store_data.
REQ-025 SB/SH/SW store: read-modify-write IDLE->RD->CAP->WR->RESP; at end of CAP, bytes at lane addr[2:0]..+size-1 replaced by low bytes of store_data, other bytes retained; merged doubleword written in WR.
REQ-026 dm_address SHALL be stable from RD or WR entry through the last memory cycle; it is 0 in IDLE and RESP.
REQ-027 dm_mem_read and dm_mem_write SHALL never be asserted in the same cycle.
REQ-028 done and fault SHALL be 0 in all states except RESP; fault=0 for successful accesses.
REQ-029 req_valid held high through RESP SHALL be accepted only at the edge after RESP (next IDLE cycle); back-to-back requests never overlap.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE regardless of state, abandoning any in-flight access (including mid-RMW, with no write issued).
REQ-031 After reset: req_ready=1, done=0, fault=0, load_data=0, dm_address=0, dm_write_data=0, dm_mem_read=0, dm_mem_write=0.

Verification
REQ-032 Memory doubleword 2 = 0x8877665544332211; LB addr=0x17 -> done 3 cycles after accept, load_data=0xFFFFFFFFFFFFFF88; LBU same addr -> 0x0000000000000088.
REQ-033 SH addr=0x12, store_data=0xABCD, doubleword 2 as above -> single dm_mem_write cycle, dm_address=2, dm_write_data=0x88776655ABCD2211.
REQ-034 SD addr=0x20, store_data=0x5 -> dm_mem_write=1 one cycle, dm_address=4, no dm_mem_read, done the following cycle.
REQ-035 LW addr=0x0A -> fault=1 with done in the cycle after accept; no memory enables asserted; load_data unchanged.
REQ-036 reset=1 during CAP of SW -> next cycle IDLE, req_ready=1, no dm_mem_write ever asserted; memory unchanged.
REQ-037 DM_WORD_ADDR=0, LD addr=0x28 -> dm_address=0x28, load_data equals doubleword at that location.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer between a 64-bit core and a doubleword-wide data memory.
// Sub-doubleword stores use read-modify-write; misaligned or illegal requests fault without touching memory.
module load_store_unit #(
    parameter int DM_WORD_ADDR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic [63:0] load_data,
    output logic        done,
    output logic        fault,
    output logic [63:0] dm_address,
    output logic [63:0] dm_write_data,
    output logic        dm_mem_write,
    output logic        dm_mem_read,
    input  logic [63:0] dm_read_data
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      r_state;
    logic        r_ready, r_done, r_fault, r_rd, r_wr;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr, r_store_data, r_load_data, r_dm_addr, r_wdata;

    logic        w_illegal;
    logic [63:0] w_dm_addr;
    logic [5:0]  w_shift;
    logic [63:0] w_rd_shifted, w_ext, w_mask, w_merged;

    always_comb begin
        w_illegal = 1'b0;
        case (funct3[1:0])
            2'b01:   w_illegal = addr[0];
            2'b10:   w_illegal = |addr[1:0];
            2'b11:   w_illegal = |addr[2:0];
            default: w_illegal = 1'b0;
        endcase
        if (funct3 == 3'b111 || (req_write && funct3[2]))
            w_illegal = 1'b1;
    end

    assign w_dm_addr = (DM_WORD_ADDR != 0) ? {3'b000, addr[63:3]} : {addr[63:3], 3'b000};
    assign w_shift   = {r_addr[2:0], 3'b000};

    // Load lane extraction and store-lane merge both work on the latched request.
    always_comb begin
        w_rd_shifted = dm_read_data >> w_shift;
        case (r_funct3)
            3'b000:  w_ext = {{56{w_rd_shifted[7]}},  w_rd_shifted[7:0]};
            3'b001:  w_ext = {{48{w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            3'b010:  w_ext = {{32{w_rd_shifted[31]}}, w_rd_shifted[31:0]};
            3'b011:  w_ext = w_rd_shifted;
            3'b100:  w_ext = {56'd0, w_rd_shifted[7:0]};
            3'b101:  w_ext = {48'd0, w_rd_shifted[15:0]};
            3'b110:  w_ext = {32'd0, w_rd_shifted[31:0]};
            default: w_ext = '0;
        endcase
        case (r_funct3[1:0])
            2'b00:   w_mask = 64'h0000_0000_0000_00FF;
            2'b01:   w_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_mask = '1;
        endcase
        w_mask   = w_mask << w_shift;
        w_merged = (dm_read_data & ~w_mask) | ((r_store_data << w_shift) & w_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_dm_addr    <= '0;
            r_wdata      <= '0;
            r_load_data  <= '0;
            r_write      <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_write      <= req_write;
                    r_funct3     <= funct3;
                    r_addr       <= addr;
                    r_store_data <= store_data;
                    r_ready      <= 1'b0;
                    if (w_illegal) begin
                        r_state <= RESP;
                        r_done  <= 1'b1;
                        r_fault <= 1'b1;
                    end else if (req_write && funct3 == 3'b011) begin
                        r_state   <= WR;
                        r_wr      <= 1'b1;
                        r_dm_addr <= w_dm_addr;
                        r_wdata   <= store_data;
                    end else begin
                        r_state   <= RD;
                        r_rd      <= 1'b1;
                        r_dm_addr <= w_dm_addr;
                    end
                end
                RD: r_state <= CAP;
                CAP: begin
                    r_rd <= 1'b0;
                    if (r_write) begin
                        r_state <= WR;
                        r_wr    <= 1'b1;
                        r_wdata <= w_merged;
                    end else begin
                        r_state     <= RESP;
                        r_done      <= 1'b1;
                        r_dm_addr   <= '0;
                        r_load_data <= w_ext;
                    end
                end
                WR: begin
                    r_state   <= RESP;
                    r_wr      <= 1'b0;
                    r_done    <= 1'b1;
                    r_dm_addr <= '0;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_ready;
    assign done          = r_done;
    assign fault         = r_fault;
    assign load_data     = r_load_data;
    assign dm_address    = r_dm_addr;
    assign dm_write_data = r_wdata;
    assign dm_mem_write  = r_wr;
    assign dm_mem_read   = r_rd;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table over loads/stores/faults plus
// hand sequences for reset mid-RMW, held request, and byte-address mode.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid2;
    logic        req_write;
    logic [2:0]  funct3;
    logic [63:0] addr, store_data;
    logic        req_ready, done, fault, dm_mem_write, dm_mem_read;
    logic [63:0] load_data, dm_address, dm_write_data;
    logic [63:0] dm_read_data = '0;
    logic        req_ready2, done2, fault2, dm_mem_write2, dm_mem_read2;
    logic [63:0] load_data2, dm_address2, dm_write_data2;
    logic [63:0] dm_read_data2 = '0;

    logic [63:0] mem [0:7] = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908,
                               64'h8877665544332211, 64'hFEDCBA9876543210,
                               64'h0, 64'h1122334455667788, 64'h0, 64'h0};
    logic [63:0] mem2 [0:7] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                                64'hCAFEF00D12345678, 64'h0, 64'h0};

    int errors = 0;
    int checks = 0;
    int n_rd = 0, n_wr = 0, n_bad = 0;
    logic [63:0] last_waddr = '0, last_wdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.DM_WORD_ADDR(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .done(done), .fault(fault), .dm_address(dm_address),
        .dm_write_data(dm_write_data), .dm_mem_write(dm_mem_write),
        .dm_mem_read(dm_mem_read), .dm_read_data(dm_read_data)
    );

    load_store_unit #(.DM_WORD_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data2), .done(done2), .fault(fault2), .dm_address(dm_address2),
        .dm_write_data(dm_write_data2), .dm_mem_write(dm_mem_write2),
        .dm_mem_read(dm_mem_read2), .dm_read_data(dm_read_data2)
    );

    // Memory models: registered read, write on the edge ending the write cycle.
    always @(posedge clk) begin
        if (dm_mem_read) dm_read_data <= mem[dm_address[2:0]];
        if (dm_mem_write) mem[dm_address[2:0]] <= dm_write_data;
        if (dm_mem_read2) dm_read_data2 <= mem2[dm_address2[5:3]];
    end

    always @(posedge clk) begin
        if (dm_mem_read) n_rd = n_rd + 1;
        if (dm_mem_write) begin
            n_wr = n_wr + 1;
            last_waddr = dm_address;
            last_wdata = dm_write_data;
        end
        if ((dm_mem_read && dm_mem_write) || (fault && !done)) n_bad = n_bad + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] sd;
        int          cyc;
        logic        flt;
        logic [63:0] ld;
        int          nrd;
        int          nwr;
        logic [63:0] waddr;
        logic [63:0] wdata;
    } vec_t;

    vec_t v [20];

    initial begin
        int cyc, rd0, wr0, k;
        logic flt_s;
        logic [63:0] ld_s;

        v[0]  = '{1'b0, 3'b000, 64'h17, 64'h0, 3, 1'b0, 64'hFFFFFFFFFFFFFF88, 2, 0, 64'h0, 64'h0};
        v[1]  = '{1'b0, 3'b100, 64'h17, 64'h0, 3, 1'b0, 64'h0000000000000088, 2, 0, 64'h0, 64'h0};
        v[2]  = '{1'b0, 3'b001, 64'h16, 64'h0, 3, 1'b0, 64'hFFFFFFFFFFFF8877, 2, 0, 64'h0, 64'h0};
        v[3]  = '{1'b0, 3'b101, 64'h12, 64'h0, 3, 1'b0, 64'h0000000000004433, 2, 0, 64'h0, 64'h0};
        v[4]  = '{1'b0, 3'b010, 64'h14, 64'h0, 3, 1'b0, 64'hFFFFFFFF88776655, 2, 0, 64'h0, 64'h0};
        v[5]  = '{1'b0, 3'b110, 64'h1C, 64'h0, 3, 1'b0, 64'h00000000FEDCBA98, 2, 0, 64'h0, 64'h0};
        v[6]  = '{1'b0, 3'b011, 64'h18, 64'h0, 3, 1'b0, 64'hFEDCBA9876543210, 2, 0, 64'h0, 64'h0};
        v[7]  = '{1'b0, 3'b010, 64'h0A, 64'h0, 1, 1'b1, 64'hFEDCBA9876543210, 0, 0, 64'h0, 64'h0};
        v[8]  = '{1'b0, 3'b001, 64'h03, 64'h0, 1, 1'b1, 64'hFEDCBA9876543210, 0, 0, 64'h0, 64'h0};
        v[9]  = '{1'b0, 3'b011, 64'h1C, 64'h0, 1, 1'b1, 64'hFEDCBA9876543210, 0, 0, 64'h0, 64'h0};
        v[10] = '{1'b0, 3'b111, 64'h10, 64'h0, 1, 1'b1, 64'hFEDCBA9876543210, 0, 0, 64'h0, 64'h0};
        v[11] = '{1'b1, 3'b100, 64'h10, 64'h1, 1, 1'b1, 64'hFEDCBA9876543210, 0, 0, 64'h0, 64'h0};
        v[12] = '{1'b1, 3'b001, 64'h12, 64'hABCD, 4, 1'b0, 64'hFEDCBA9876543210, 2, 1, 64'h2, 64'h88776655ABCD2211};
        v[13] = '{1'b1, 3'b011, 64'h20, 64'h5, 2, 1'b0, 64'hFEDCBA9876543210, 0, 1, 64'h4, 64'h5};
        v[14] = '{1'b1, 3'b000, 64'h01, 64'hFFEE, 4, 1'b0, 64'hFEDCBA9876543210, 2, 1, 64'h0, 64'h070605040302EE00};
        v[15] = '{1'b1, 3'b010, 64'h0C, 64'h12345678DEADBEEF, 4, 1'b0, 64'hFEDCBA9876543210, 2, 1, 64'h1, 64'hDEADBEEF0B0A0908};
        v[16] = '{1'b0, 3'b011, 64'h08, 64'h0, 3, 1'b0, 64'hDEADBEEF0B0A0908, 2, 0, 64'h0, 64'h0};
        v[17] = '{1'b0, 3'b000, 64'h00, 64'h0, 3, 1'b0, 64'h0, 2, 0, 64'h0, 64'h0};
        v[18] = '{1'b0, 3'b000, 64'h01, 64'h0, 3, 1'b0, 64'hFFFFFFFFFFFFFFEE, 2, 0, 64'h0, 64'h0};
        v[19] = '{1'b0, 3'b011, 64'h20, 64'h0, 3, 1'b0, 64'h5, 2, 0, 64'h0, 64'h0};

        reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
        req_write = 1'b0; funct3 = '0; addr = '0; store_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", {63'd0, req_ready}, 64'd1);
        chk("rst done", {63'd0, done}, 64'd0);
        chk("rst fault", {63'd0, fault}, 64'd0);
        chk("rst load_data", load_data, 64'd0);
        chk("rst dm_address", dm_address, 64'd0);
        chk("rst dm_write_data", dm_write_data, 64'd0);
        chk("rst enables", {62'd0, dm_mem_read, dm_mem_write}, 64'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_write = v[i].w; funct3 = v[i].f3;
            addr = v[i].a; store_data = v[i].sd;
            rd0 = n_rd; wr0 = n_wr;
            @(posedge clk); #1;
            // Scramble inputs after acceptance; the unit must use its latched copy.
            req_valid = 1'b0; req_write = ~v[i].w; funct3 = 3'b111;
            addr = ~v[i].a; store_data = ~v[i].sd;
            cyc = 1;
            while (!done && cyc < 12) begin
                @(posedge clk); #1;
                cyc++;
            end
            flt_s = fault; ld_s = load_data;
            @(posedge clk); #1;
            chk($sformatf("v%0d cycles", i), 64'(cyc), 64'(v[i].cyc));
            chk($sformatf("v%0d fault", i), {63'd0, flt_s}, {63'd0, v[i].flt});
            chk($sformatf("v%0d load_data", i), ld_s, v[i].ld);
            chk($sformatf("v%0d reads", i), 64'(n_rd - rd0), 64'(v[i].nrd));
            chk($sformatf("v%0d writes", i), 64'(n_wr - wr0), 64'(v[i].nwr));
            chk($sformatf("v%0d idle", i), {62'd0, req_ready, done}, 64'd2);
            if (v[i].nwr != 0) begin
                chk($sformatf("v%0d waddr", i), last_waddr, v[i].waddr);
                chk($sformatf("v%0d wdata", i), last_wdata, v[i].wdata);
            end
        end

        // Reset during CAP of a SW: abandon without writing.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010;
        addr = 64'h28; store_data = 64'h99999999;
        wr0 = n_wr;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rst-cap ready", {63'd0, req_ready}, 64'd1);
        chk("rst-cap enables", {61'd0, dm_mem_read, dm_mem_write, done}, 64'd0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst-cap writes", 64'(n_wr - wr0), 64'd0);
        chk("rst-cap mem", mem[5], 64'h1122334455667788);
        chk("rst-cap load_data", load_data, 64'd0);

        // req_valid held through RESP: next acceptance only after the IDLE cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b011; addr = 64'h20;
        k = 0;
        while (!done && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("hold resp ready", {62'd0, req_ready, done}, 64'd1);
        @(posedge clk); #1;
        chk("hold idle", {61'd0, req_ready, dm_mem_read, done}, 64'd4);
        @(posedge clk); #1;
        chk("hold reaccept", {62'd0, req_ready, dm_mem_read}, 64'd1);
        @(negedge clk) req_valid = 1'b0;
        k = 0;
        while (!done && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("hold second done", {63'd0, done}, 64'd1);
        chk("hold load_data", load_data, 64'd5);
        @(posedge clk);

        // Byte-address mode instance.
        @(negedge clk);
        req_valid2 = 1'b1; req_write = 1'b0; funct3 = 3'b011; addr = 64'h28;
        @(posedge clk); #1 req_valid2 = 1'b0;
        chk("byte-mode dm_address", dm_address2, 64'h28);
        chk("byte-mode read", {63'd0, dm_mem_read2}, 64'd1);
        k = 0;
        while (!done2 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("byte-mode done", {63'd0, done2}, 64'd1);
        chk("byte-mode load_data", load_data2, 64'hCAFEF00D12345678);
        @(posedge clk); #1;

        chk("no overlap / stray fault", 64'(n_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
